sm83_sequencer: RTL and testbench

SM83_SEQUENCER -- requirements
Module: sm83_sequencer

---
 rtl/sm83_sequencer.sv | 162 ++++++++++++++++
 tb/tb_sm83_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sm83_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sm83_sequencer
// Description : SM83 T-state / M-cycle sequencer. Tracks the T-state and
//               M-cycle counters, latches the opcode and CB-bank flag on
//               fetch cycles, and steps through RUN, HALT and interrupt
//               dispatch (INT). It also implements the HALT bug, where the
//               PC increment for one fetch is suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module sm83_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce,
  input  logic [7:0] i_mem_rd_data,
  input  logic       i_last_mcycle,
  input  logic       i_halt_req,
  input  logic       i_irq_pending,
  input  logic       i_ime,
  output logic [7:0] o_opcode,
  output logic       o_bank_cb,
  output logic       o_in_halt,
  output logic       o_in_int,
  output logic [1:0] o_tstate,
  output logic [2:0] o_mcycle,
  output logic       o_fetch,
  output logic       o_pc_inc_inhibit
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_INT  = 2'd2
  } state_t;

  localparam logic [7:0] C_OP_CB      = 8'hCB;
  localparam logic [7:0] C_OP_HALT    = 8'h76;
  localparam logic [2:0] C_MCYCLE_MAX = 3'd7;
  localparam logic [2:0] C_INT_LAST   = 3'd4;

  state_t     r_state;
  logic [1:0] r_tstate;
  logic [2:0] r_mcycle;
  logic [7:0] r_opcode;
  logic       r_bank_cb;
  logic       r_pc_inc_inhibit;

  state_t     w_state_nx;
  logic [1:0] w_tstate_nx;
  logic [2:0] w_mcycle_nx;
  logic [7:0] w_opcode_nx;
  logic       w_bank_cb_nx;
  logic       w_pc_inc_inhibit_nx;

  logic       w_boundary;
  logic       w_cb_pending;
  logic       w_irq_take;
  logic       w_halt_bug;

  // Last T-state of an enabled M-cycle; every M-cycle level decision happens here.
  assign w_boundary   = i_ce && (r_tstate == 2'd3);
  // A 0xCB prefix has been fetched but its CB-bank opcode has not; interrupts must wait.
  assign w_cb_pending = (r_opcode == C_OP_CB) && !r_bank_cb;
  assign w_irq_take   = i_ime && i_irq_pending && !w_cb_pending;
  // HALT with interrupts disabled but one already pending: no halt, next PC increment lost.
  assign w_halt_bug   = i_halt_req && !r_bank_cb && !i_ime && i_irq_pending;

  // State register and datapath registers; async reset abandons everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_RUN;
      r_tstate         <= 2'd0;
      r_mcycle         <= 3'd0;
      r_opcode         <= 8'h00;
      r_bank_cb        <= 1'b0;
      r_pc_inc_inhibit <= 1'b0;
    end else begin
      r_state          <= w_state_nx;
      r_tstate         <= w_tstate_nx;
      r_mcycle         <= w_mcycle_nx;
      r_opcode         <= w_opcode_nx;
      r_bank_cb        <= w_bank_cb_nx;
      r_pc_inc_inhibit <= w_pc_inc_inhibit_nx;
    end
  end

  // Next-state logic: tstate counts every enabled clock, the rest moves only at boundaries.
  always_comb begin
    w_state_nx          = r_state;
    w_tstate_nx         = i_ce ? (r_tstate + 2'd1) : r_tstate;
    w_mcycle_nx         = r_mcycle;
    w_opcode_nx         = r_opcode;
    w_bank_cb_nx        = r_bank_cb;
    w_pc_inc_inhibit_nx = r_pc_inc_inhibit;

    if (w_boundary) begin
      // Inhibit covers only the single M-cycle after the HALT-bug fetch.
      w_pc_inc_inhibit_nx = 1'b0;
      case (r_state)
        ST_RUN: begin
          if (!i_last_mcycle) begin
            if (r_mcycle != C_MCYCLE_MAX) begin
              w_mcycle_nx = r_mcycle + 3'd1;
            end
          end else if (w_irq_take) begin
            w_state_nx  = ST_INT;
            w_mcycle_nx = 3'd0;
          end else if (i_halt_req && !r_bank_cb && !w_halt_bug) begin
            w_state_nx  = ST_HALT;
            w_mcycle_nx = 3'd0;
            w_opcode_nx = C_OP_HALT;
          end else begin
            w_opcode_nx         = i_mem_rd_data;
            w_bank_cb_nx        = w_cb_pending;
            w_mcycle_nx         = 3'd0;
            w_pc_inc_inhibit_nx = w_halt_bug;
          end
        end
        ST_HALT: begin
          if (i_irq_pending) begin
            w_mcycle_nx = 3'd0;
            if (i_ime) begin
              w_state_nx = ST_INT;
            end else begin
              w_state_nx   = ST_RUN;
              w_opcode_nx  = i_mem_rd_data;
              w_bank_cb_nx = 1'b0;
            end
          end
        end
        ST_INT: begin
          if (r_mcycle == C_INT_LAST) begin
            w_state_nx   = ST_RUN;
            w_opcode_nx  = i_mem_rd_data;
            w_bank_cb_nx = 1'b0;
            w_mcycle_nx  = 3'd0;
          end else begin
            w_mcycle_nx = r_mcycle + 3'd1;
          end
        end
        default: begin
          w_state_nx  = ST_RUN;
          w_mcycle_nx = 3'd0;
        end
      endcase
    end
  end

  assign o_opcode         = r_opcode;
  assign o_bank_cb        = r_bank_cb;
  assign o_in_halt        = (r_state == ST_HALT);
  assign o_in_int         = (r_state == ST_INT);
  assign o_tstate         = r_tstate;
  assign o_mcycle         = r_mcycle;
  assign o_pc_inc_inhibit = r_pc_inc_inhibit;
  // The fetch strobe follows the current state and last_mcycle combinationally.
  assign o_fetch          = ((r_state == ST_RUN) && i_last_mcycle) ||
                            (r_state == ST_HALT) ||
                            ((r_state == ST_INT) && (r_mcycle == C_INT_LAST));

endmodule
`default_nettype wire

// File: tb/tb_sm83_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm83_sequencer
// Description : Directed, table-driven bench for sm83_sequencer plus
//               hand-written sequences for HALT bug, saturation, ce gating
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm83_sequencer;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [7:0] mem;
  logic       last;
  logic       halt;
  logic       irq;
  logic       ime;
  logic [7:0] opcode;
  logic       bank_cb;
  logic       in_halt;
  logic       in_int;
  logic [1:0] tstate;
  logic [2:0] mcycle;
  logic       fetch;
  logic       inhibit;

  int total;
  int bad;

  sm83_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .i_ce             (ce),
    .i_mem_rd_data    (mem),
    .i_last_mcycle    (last),
    .i_halt_req       (halt),
    .i_irq_pending    (irq),
    .i_ime            (ime),
    .o_opcode         (opcode),
    .o_bank_cb        (bank_cb),
    .o_in_halt        (in_halt),
    .o_in_int         (in_int),
    .o_tstate         (tstate),
    .o_mcycle         (mcycle),
    .o_fetch          (fetch),
    .o_pc_inc_inhibit (inhibit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ncyc;
    logic       ce;
    logic       last;
    logic       halt;
    logic       irq;
    logic       ime;
    logic [7:0] mem;
    logic [7:0] e_opcode;
    logic       e_bank;
    logic       e_halt;
    logic       e_int;
    logic [1:0] e_tstate;
    logic [2:0] e_mcycle;
    logic       e_fetch;
    logic       e_inhibit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, int nc, logic c, logic l, logic h, logic q, logic m,
                              logic [7:0] d, logic [7:0] eo, logic eb, logic eh, logic ei,
                              logic [1:0] et, logic [2:0] em, logic ef, logic ep);
    vec_t v;
    v.name = n; v.ncyc = nc; v.ce = c; v.last = l; v.halt = h; v.irq = q; v.ime = m;
    v.mem = d; v.e_opcode = eo; v.e_bank = eb; v.e_halt = eh; v.e_int = ei;
    v.e_tstate = et; v.e_mcycle = em; v.e_fetch = ef; v.e_inhibit = ep;
    return v;
  endfunction

  // Compares every output against an expected set; one FAIL line per mismatch.
  task automatic check(string n, logic [7:0] eo, logic eb, logic eh, logic ei,
                       logic [1:0] et, logic [2:0] em, logic ef, logic ep);
    total++;
    if (opcode !== eo || bank_cb !== eb || in_halt !== eh || in_int !== ei ||
        tstate !== et || mcycle !== em || fetch !== ef || inhibit !== ep) begin
      bad++;
      $display("FAIL %s: got op=%h cb=%b halt=%b int=%b t=%0d m=%0d f=%b inh=%b want op=%h cb=%b halt=%b int=%b t=%0d m=%0d f=%b inh=%b",
               n, opcode, bank_cb, in_halt, in_int, tstate, mcycle, fetch, inhibit,
               eo, eb, eh, ei, et, em, ef, ep);
    end
  endtask

  task automatic drive(logic c, logic l, logic h, logic q, logic m, logic [7:0] d);
    ce = c; last = l; halt = h; irq = q; ime = m; mem = d;
  endtask

  task automatic clocks(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] f_op;
  logic       f_cb;
  logic [1:0] f_t;
  logic [2:0] f_m;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    //             name          n  ce l  h  q  m  mem    op    cb h  i  t  m  f  inh
    vecs.push_back(mk("fetch3E",  4, 1, 1, 0, 0, 0, 8'h3E, 8'h3E, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("mcyc1",    4, 1, 0, 0, 0, 0, 8'h00, 8'h3E, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("ce0hold",  2, 0, 0, 0, 0, 0, 8'h00, 8'h3E, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("t3",       3, 1, 0, 0, 0, 0, 8'h00, 8'h3E, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("fetchCB",  1, 1, 1, 0, 0, 0, 8'hCB, 8'hCB, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("cbNoInt",  4, 1, 1, 0, 1, 1, 8'h7C, 8'h7C, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("cbClear",  4, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("fetch76",  4, 1, 1, 0, 0, 0, 8'h76, 8'h76, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltIn",   4, 1, 1, 1, 0, 0, 8'h11, 8'h76, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltStay", 8, 1, 0, 1, 0, 0, 8'h11, 8'h76, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltWake", 4, 1, 0, 0, 1, 0, 8'h42, 8'h42, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fetch76b", 4, 1, 1, 0, 0, 0, 8'h76, 8'h76, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltIn2",  4, 1, 1, 1, 0, 1, 8'h11, 8'h76, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltInt",  4, 1, 0, 0, 1, 1, 8'h11, 8'h76, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("intM1",    4, 1, 1, 1, 0, 0, 8'h99, 8'h76, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("intM3",    8, 1, 1, 1, 0, 0, 8'h99, 8'h76, 0, 0, 1, 0, 3, 0, 0));
    vecs.push_back(mk("intM4",    4, 1, 1, 1, 0, 0, 8'h99, 8'h76, 0, 0, 1, 0, 4, 1, 0));
    vecs.push_back(mk("intExit",  4, 1, 0, 0, 0, 0, 8'h5A, 8'h5A, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("irqEntry", 4, 1, 1, 0, 1, 1, 8'h00, 8'h5A, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("intRun",  20, 1, 0, 0, 0, 0, 8'hA7, 8'hA7, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fetch76c", 4, 1, 1, 0, 0, 0, 8'h76, 8'h76, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("haltBug",  4, 1, 1, 1, 1, 0, 8'h23, 8'h23, 0, 0, 0, 0, 0, 1, 1));

    // Reset values while reset is held, with clocks running.
    clocks(2);
    check("reset", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ce, vecs[i].last, vecs[i].halt, vecs[i].irq, vecs[i].ime, vecs[i].mem);
      clocks(vecs[i].ncyc);
      check(vecs[i].name, vecs[i].e_opcode, vecs[i].e_bank, vecs[i].e_halt, vecs[i].e_int,
            vecs[i].e_tstate, vecs[i].e_mcycle, vecs[i].e_fetch, vecs[i].e_inhibit);
    end

    // HALT bug: inhibit must persist through the whole next M-cycle, across ce=0 gaps.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    clocks(1);
    check("inhT1", 8'h23, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b1);
    ce = 1'b0;
    clocks(3);
    check("inhGate", 8'h23, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b1);
    ce = 1'b1;
    clocks(2);
    check("inhT3", 8'h23, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 1'b1);
    clocks(1);
    check("inhOff", 8'h23, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0);

    // mcycle saturates at 7 when last_mcycle never arrives.
    clocks(7 * 4);
    check("mcycSat", 8'h23, 1'b0, 1'b0, 1'b0, 2'd0, 3'd7, 1'b0, 1'b0);

    // Enter INT, advance to mcycle 2, tstate 2, then freeze with ce=0.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    clocks(4);
    check("int2Entry", 8'h23, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    clocks(10);
    check("intMid", 8'h23, 1'b0, 1'b0, 1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
    f_op = opcode; f_cb = bank_cb; f_t = tstate; f_m = mcycle;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    clocks(10);
    check("ceFreeze", f_op, f_cb, 1'b0, 1'b1, f_t, f_m, 1'b0, 1'b0);

    // Asynchronous reset mid-INT takes effect before any clock edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("asyncRst", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    clocks(1);
    rst = 1'b0;
    clocks(1);
    check("postRst", 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
